uart_frame_sched: RTL and testbench
===================================

# uart_frame_sched

Round-robin scheduler that shares the single byte-wide UART transmitter between N telemetry requesters, such as per-wheel speed reporters on the chassis. It latches one requester's fixed-size payload and wraps it in a frame: header, channel id, payload, checksum. It then feeds the frame to the transmitter one byte per handshake, using the transmitter's `uart_en` rising-edge start and its `tx_flag` busy indication. It sits between the chassis control logic and the UART transmitter.

## Interface
- `N_CH`, default 4: number of requesters (2..8).
- `PAY_BYTES`, default 4: payload bytes per frame (1..15).
- `IFG_CYCLES`, default 0: idle `sys_clk` cycles inserted after each frame; 0 means no gap.
- `TIMEOUT`, default 16: maximum cycles `uart_en` is held high waiting for `tx_busy`.
- `sys_clk`, in, 1: system clock. The block uses one clock; reset is synchronous and active-high.
- `sys_rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_CH`: frame request per channel, level. Held until granted.
- `payload`, in, `N_CH*PAY_BYTES*8`:
  - Channel i occupies `[i*PAY_BYTES*8 +: PAY_BYTES*8]`.
  - Byte 0 is the LSB byte and is sent first.
- `grant`, out, `N_CH`: one-hot, one-cycle pulse marking the cycle the payload was captured.
- `uart_en`, out, 1: transmitter start. Its rising edge starts one byte.
- `uart_din`, out, 8: byte to transmit. Stable from `uart_en` rise until `tx_busy` is seen high.
- `tx_busy`, in, 1: transmitter busy; connects to the transmitter's `tx_flag`.
- `frame_busy`, out, 1: high whenever state ≠ IDLE.
- `frame_done`, out, 1: one-cycle pulse after the checksum byte completes.
- `err_timeout`, out, 1: one-cycle pulse when a byte start times out.

## Operation
- Frame format, `PAY_BYTES+4` bytes: 8'h55, 8'hAA, channel id (zero-extended), payload bytes 0..PAY_BYTES-1, checksum.
- Checksum: mod-256 sum of the channel id and all payload bytes. Header bytes are excluded.
- Arbitration:
  - Round-robin; the search starts at the channel after the last granted one.
  - After reset, channel 0 has highest priority.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, when `|req`:
  - capture the winner's payload and id;
  - pulse `grant`;
  - update the pointer;
  - set byte index k=0;
  - go to LOAD.
- LOAD: drive `uart_din` = frame byte k, set `uart_en`=1, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - When `tx_busy`=1: set `uart_en`=0 and go to WAIT_DONE.
  - Otherwise, when the counter reaches `TIMEOUT`-1: set `uart_en`=0, pulse `err_timeout`, drop the frame (no `frame_done`), go to IDLE.
- WAIT_DONE, when `tx_busy`=0:
  - If k is the last byte: pulse `frame_done`, then go to GAP if `IFG_CYCLES`>0, else to IDLE.
  - Otherwise: k++ and go to LOAD.
- GAP: count `IFG_CYCLES` cycles, then go to IDLE.
- `req` changes during a frame are ignored. The captured payload is used even if the source changes.
- A requester that drops `req` before being granted is simply not served. There is no stored request.
- Reset mid-frame:
  - Outputs return to reset values at once; the partial frame is abandoned.
  - The transmitter finishes its current byte independently.

## Timing
- Reset values:
  - `grant`=0, `uart_en`=0, `uart_din`=0, `frame_busy`=0, `frame_done`=0, `err_timeout`=0.
  - Pointer selects channel 0 first; state = IDLE.
- `req` asserted at edge t in IDLE: `grant` is high during cycle t+1, and `uart_en` rises at t+2.
- The transmitter's own edge detect asserts `tx_busy` about 3 cycles after `uart_en` rises. `uart_en` therefore stays high for about 3 cycles; `TIMEOUT` gives margin.
- `uart_en` stays low for at least the duration of one byte (`tx_busy` high) before the next rise. This satisfies the transmitter's 2-flop edge detect.
- Back-to-back frames: when `IFG_CYCLES`=0, IDLE lasts one cycle between `frame_done` and the next `grant`.
- `tx_busy` already high on entry to WAIT_BUSY (a stale byte): it is treated as acknowledge.

## Structure
- Package `uart_frame_pkg`:
  - state encoding;
  - header constants `HDR0`=8'h55 and `HDR1`=8'hAA;
  - frame-length function `PAY_BYTES+4`.
- Sub-module `rr_arbiter`: N-way round-robin request→one-hot grant, with pointer update on an accept input. It is reusable elsewhere in the chassis.
- The byte mux and checksum accumulator stay in the top level. The checksum is accumulated as bytes are sent, or precomputed at capture.

## Test plan
- Reset → all outputs 0 and state IDLE; hold `req`=4'b0000 for 100 cycles → `uart_en` stays 0.
- `req`[2] with payload 32'h04030201, transmitter model asserting busy 3 cycles after `uart_en` and holding it 40 cycles → bytes 55 AA 02 01 02 03 04 0C, then one `frame_done` pulse.
- `req`=4'b1111 held → grant order 0,1,2,3,0; a frame for channel 1 after channel 3 only when `req`[0] is low.
- Transmitter model never asserts busy → `uart_en` high for exactly 16 cycles, `err_timeout` pulses once, return to IDLE, no `frame_done`.
- Payload bytes FF FF FF FF on channel 3 → checksum 8'hFF (3+0x3FC mod 256).
- `sys_rst` asserted during the 5th byte → next cycle all outputs at reset values; a new `req`[0] restarts a full frame with HDR0.

Source files
------------

// File: rtl/uart_frame_sched_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
//   Shared definitions for the UART frame scheduler: FSM state encoding,
//   frame header constants and the frame-length helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  // Two header bytes, channel id, payload, checksum.
  function automatic int frame_len(input int pay_bytes);
    return pay_bytes + 4;
  endfunction

endpackage

// File: rtl/uart_frame_sched_if.sv
// ----------------------------------------------------------------------------
// uart_frame_sched_if
//   Bundles the requester side (req/payload/grant), the transmitter handshake
//   (uart_en/uart_din/tx_busy) and the frame status pulses.
//   master : the scheduler (drives grant, uart_en, uart_din, status)
//   slave  : requesters + transmitter (drive req, payload, tx_busy)
// ----------------------------------------------------------------------------
interface uart_frame_sched_if #(
  parameter int N_CH      = 4,
  parameter int PAY_BYTES = 4
);
  logic [N_CH-1:0]             req;
  logic [N_CH*PAY_BYTES*8-1:0] payload;
  logic [N_CH-1:0]             grant;
  logic                        uart_en;
  logic [7:0]                  uart_din;
  logic                        tx_busy;
  logic                        frame_busy;
  logic                        frame_done;
  logic                        err_timeout;

  modport master (
    input  req, payload, tx_busy,
    output grant, uart_en, uart_din, frame_busy, frame_done, err_timeout
  );

  modport slave (
    output req, payload, tx_busy,
    input  grant, uart_en, uart_din, frame_busy, frame_done, err_timeout
  );
endinterface

// File: rtl/uart_frame_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   N-way round-robin arbiter. Combinational one-hot grant from the request
//   vector; the priority pointer moves to the channel after the winner when
//   i_accept is high in a cycle with a valid grant.
//   clk, srst      : clock, synchronous active-high reset (pointer -> 0)
//   i_req          : request vector
//   i_accept       : consumer takes the current grant this cycle
//   o_grant        : one-hot grant (combinational)
//   o_grant_idx    : binary index of the granted channel
//   o_valid        : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_accept,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_valid
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;

  // Scan from the pointer upward (wrapping); first request found wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_valid     = 1'b0;
    w_idx       = '0;
    for (int off = 0; off < N; off++) begin
      w_idx = IW'((int'(r_ptr) + off) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_ptr <= '0;
    end else if (i_accept && o_valid) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/uart_frame_sched.sv
// ----------------------------------------------------------------------------
// uart_frame_sched
//   Shares one byte-wide UART transmitter between N_CH requesters. Latches
//   the round-robin winner's payload and sends 55 AA id payload[0..] csum,
//   one byte per uart_en rise / tx_busy handshake.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (master)     : req/payload in, grant out, uart_en/uart_din out,
//                      tx_busy in, frame_busy/frame_done/err_timeout out
// ----------------------------------------------------------------------------
module uart_frame_sched
  import uart_frame_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PAY_BYTES  = 4,
  parameter int IFG_CYCLES = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  uart_frame_sched_if.master bus
);
  localparam int FLEN    = frame_len(PAY_BYTES);
  localparam int KW      = $clog2(FLEN);
  localparam int IW      = $clog2(N_CH);
  localparam int PW      = PAY_BYTES * 8;
  localparam int SW      = $clog2(N_CH * PW);
  localparam int BW      = $clog2(PW);
  localparam int CNT_MAX = (TIMEOUT > IFG_CYCLES) ? TIMEOUT : IFG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          r_state, w_state_next;
  logic [KW-1:0]   r_k, w_k_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [IW-1:0]   r_id;
  logic [PW-1:0]   r_pay;
  logic [7:0]      r_csum;
  logic [N_CH-1:0] r_grant, w_grant_next;
  logic            r_en, w_en_next;
  logic [7:0]      r_din, w_din_next;
  logic            r_done, w_done_next;
  logic            r_err, w_err_next;
  logic            w_capture;

  logic [N_CH-1:0] w_arb_grant;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic            w_arb_accept;
  logic [PW-1:0]   w_sel_pay;
  logic [7:0]      w_sel_sum;
  logic [7:0]      w_byte;
  logic [7:0]      w_pay_byte [PAY_BYTES];

  // The pointer only advances when IDLE actually takes the winner.
  assign w_arb_accept = (r_state == ST_IDLE);

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk        (sys_clk),
    .srst       (sys_rst),
    .i_req      (bus.req),
    .i_accept   (w_arb_accept),
    .o_grant    (w_arb_grant),
    .o_grant_idx(w_arb_idx),
    .o_valid    (w_arb_valid)
  );

  assign w_sel_pay = bus.payload[SW'(int'(w_arb_idx) * PW) +: PW];

  // Checksum precomputed at capture so the last byte needs no extra cycle.
  always_comb begin
    w_sel_sum = 8'(w_arb_idx);
    for (int b = 0; b < PAY_BYTES; b++) begin
      w_sel_sum = w_sel_sum + w_sel_pay[b*8 +: 8];
    end
  end

  for (genvar gi = 0; gi < PAY_BYTES; gi++) begin : g_pay_byte
    assign w_pay_byte[gi] = r_pay[gi*8 +: 8];
  end

  // Frame byte mux: k=0,1 header, k=2 id, then payload, last is checksum.
  always_comb begin
    w_byte = r_csum;
    if (r_k == KW'(0)) begin
      w_byte = HDR0;
    end else if (r_k == KW'(1)) begin
      w_byte = HDR1;
    end else if (r_k == KW'(2)) begin
      w_byte = 8'(r_id);
    end else if (r_k < KW'(FLEN - 1)) begin
      w_byte = r_pay[BW'((int'(r_k) - 3) * 8) +: 8];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_cnt_next   = r_cnt;
    w_grant_next = '0;
    w_en_next    = r_en;
    w_din_next   = r_din;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_capture    = 1'b1;
          w_grant_next = w_arb_grant;
          w_k_next     = '0;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_din_next   = w_byte;
        w_en_next    = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A busy already high here (stale byte) is taken as the acknowledge.
        if (bus.tx_busy) begin
          w_en_next    = 1'b0;
          w_state_next = ST_WAIT_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_en_next    = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (r_k == KW'(FLEN - 1)) begin
            w_done_next = 1'b1;
            if (IFG_CYCLES > 0) begin
              w_cnt_next   = '0;
              w_state_next = ST_GAP;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_k_next     = r_k + 1'b1;
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (r_cnt == CW'(IFG_CYCLES - 1)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_pay   <= '0;
      r_csum  <= '0;
      r_grant <= '0;
      r_en    <= 1'b0;
      r_din   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_cnt   <= w_cnt_next;
      r_grant <= w_grant_next;
      r_en    <= w_en_next;
      r_din   <= w_din_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (w_capture) begin
        r_id   <= w_arb_idx;
        r_pay  <= w_sel_pay;
        r_csum <= w_sel_sum;
      end
    end
  end

  assign bus.grant       = r_grant;
  assign bus.uart_en     = r_en;
  assign bus.uart_din    = r_din;
  assign bus.frame_busy  = (r_state != ST_IDLE);
  assign bus.frame_done  = r_done;
  assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_uart_frame_sched.sv
module tb_uart_frame_sched;
  localparam int N_CH       = 4;
  localparam int PAY_BYTES  = 4;
  localparam int IFG_CYCLES = 0;
  localparam int TIMEOUT    = 16;
  localparam int FLEN       = PAY_BYTES + 4;
  localparam int PW         = PAY_BYTES * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_sched_if #(.N_CH(N_CH), .PAY_BYTES(PAY_BYTES)) u_if ();

  uart_frame_sched #(
    .N_CH(N_CH), .PAY_BYTES(PAY_BYTES), .IFG_CYCLES(IFG_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (u_if)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q[$];
  int         pend = 0, busy_left = 0, tx_hold = 40;
  bit         tx_mute = 1'b0;
  bit         en_prev = 1'b0;
  int         en_run = 0, last_en_run = 0, en_rises = 0;
  int         done_cnt = 0, err_cnt = 0;
  int         model_last = N_CH - 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requester after the last served one.
  function automatic int rr_pick(input logic [N_CH-1:0] r, input int last);
    for (int o = 1; o <= N_CH; o++) begin
      if (r[(last + o) % N_CH]) return (last + o) % N_CH;
    end
    return -1;
  endfunction

  function automatic void build_frame(input int ch, input logic [PW-1:0] p);
    int sum;
    sum = ch;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'(ch));
    for (int b = 0; b < PAY_BYTES; b++) begin
      exp_q.push_back(p[b*8 +: 8]);
      sum += int'(p[b*8 +: 8]);
    end
    exp_q.push_back(8'(sum % 256));
  endfunction

  task automatic rand_payload();
    for (int w = 0; w < N_CH * PAY_BYTES / 4; w++) u_if.payload[w*32 +: 32] = $urandom();
  endtask

  // Monitor + transmitter model: busy 3 cycles after a uart_en rise, held tx_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.frame_done) done_cnt++;
      if (u_if.err_timeout) err_cnt++;
      if (u_if.uart_en) en_run++;
      else if (en_run > 0) begin
        last_en_run = en_run;
        en_run = 0;
      end
      if (u_if.uart_en && pend > 0 && rx_q.size() > 0)
        check("din_stable", u_if.uart_din, rx_q[$]);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) u_if.tx_busy = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          u_if.tx_busy = 1'b1;
          busy_left = tx_hold;
        end
      end else if (u_if.uart_en && !en_prev && !tx_mute) begin
        rx_q.push_back(u_if.uart_din);
        pend = 3;
      end
      if (u_if.uart_en && !en_prev) en_rises++;
      en_prev = u_if.uart_en;
    end
  end

  // clr_mode: 0 keep req, 1 drop granted bit, 2 drop all after grant.
  task automatic do_frame(input logic [N_CH-1:0] rq, input int clr_mode, output int got_ch);
    int lat, exp_ch;
    bit seen;
    logic [PW-1:0] snap;
    got_ch = -1;
    u_if.req = rq;
    exp_ch = rr_pick(rq, model_last);
    snap = u_if.payload[exp_ch*PW +: PW];
    rx_q.delete();
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (u_if.grant != '0) begin
        lat = c;
        break;
      end
    end
    check("grant_latency", lat, 1);
    if (lat == 0) return;
    for (int i = 0; i < N_CH; i++) if (u_if.grant[i]) got_ch = i;
    check("grant_onehot", u_if.grant, 64'(1) << exp_ch);
    check("frame_busy", u_if.frame_busy, 1);
    model_last = exp_ch;
    build_frame(exp_ch, snap);
    if (clr_mode == 1) u_if.req = u_if.req & ~u_if.grant;
    else if (clr_mode == 2) u_if.req = '0;
    rand_payload();  // source changes after capture must not leak into the frame
    step();
    check("en_after_grant", u_if.uart_en, 1);
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (u_if.frame_done) begin
        seen = 1'b1;
        break;
      end
      if (u_if.err_timeout) break;
    end
    check("frame_done_seen", seen, 1);
    check("byte_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
    $display("[TB] frame ch=%0d bytes=%0d csum=%02h", got_ch, rx_q.size(), exp_q[FLEN-1]);
  endtask

  initial begin
    int ch, e0, d0, lat;
    bit seen;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [N_CH-1:0] nb;

    u_if.req = '0;
    u_if.payload = '0;
    u_if.tx_busy = 1'b0;
    repeat (3) step();
    check("rst_grant", u_if.grant, 0);
    check("rst_uart_en", u_if.uart_en, 0);
    check("rst_uart_din", u_if.uart_din, 0);
    check("rst_frame_busy", u_if.frame_busy, 0);
    check("rst_frame_done", u_if.frame_done, 0);
    check("rst_err_timeout", u_if.err_timeout, 0);
    rst = 1'b0;
    repeat (100) step();
    check("idle_no_uart_en", en_rises, 0);
    check("idle_not_busy", u_if.frame_busy, 0);

    // Round robin with all requests held.
    tx_hold = 5;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      do_frame(4'b1111, (i == 4) ? 2 : 0, ch);
      check("rr_order", ch, rr_exp[i]);
    end
    do_frame(4'b1000, 1, ch);
    check("rr_ch3", ch, 3);
    do_frame(4'b1011, 1, ch);
    check("rr_ch0_beats_ch1", ch, 0);
    do_frame(4'b0010, 1, ch);
    check("rr_ch1_req0_low", ch, 1);

    // Directed frame: ch2, payload 04030201, busy held 40 cycles.
    tx_hold = 40;
    rand_payload();
    u_if.payload[2*PW +: PW] = 32'h04030201;
    do_frame(4'b0100, 1, ch);
    if (rx_q.size() == FLEN) check("dir_csum", rx_q[FLEN-1], 8'h0C);

    // All-FF payload on channel 3.
    tx_hold = 6;
    rand_payload();
    u_if.payload[3*PW +: PW] = 32'hFFFFFFFF;
    do_frame(4'b1000, 1, ch);
    if (rx_q.size() == FLEN) check("ff_csum", rx_q[FLEN-1], 8'hFF);

    // Randomized requests and busy durations.
    for (int it = 0; it < 25; it++) begin
      tx_hold = $urandom_range(1, 30);
      nb = N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if ((u_if.req | nb) == '0) nb[$urandom_range(0, N_CH - 1)] = 1'b1;
      rand_payload();
      do_frame(u_if.req | nb, 1, ch);
    end
    u_if.req = '0;
    repeat (3) step();

    // Transmitter never answers.
    tx_mute = 1'b1;
    e0 = err_cnt;
    d0 = done_cnt;
    u_if.req = 4'b0001;
    ch = rr_pick(4'b0001, model_last);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (u_if.grant != '0) begin
        lat = c;
        break;
      end
    end
    check("to_grant_latency", lat, 1);
    u_if.req = '0;
    model_last = ch;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (u_if.err_timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_err_seen", seen, 1);
    repeat (3) step();
    check("to_en_len", last_en_run, TIMEOUT);
    check("to_err_once", err_cnt - e0, 1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_idle", u_if.frame_busy, 0);
    tx_mute = 1'b0;
    $display("[TB] timeout ch=%0d en_len=%0d", ch, last_en_run);

    // Reset during the 5th byte.
    tx_hold = 10;
    rand_payload();
    rx_q.delete();
    u_if.req = 4'b0001;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (u_if.grant != '0) begin
        lat = c;
        break;
      end
    end
    check("rs_grant_latency", lat, 1);
    u_if.req = '0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (rx_q.size() >= 5) begin
        seen = 1'b1;
        break;
      end
    end
    check("rs_reach_byte5", seen, 1);
    rst = 1'b1;
    step();
    check("rs_grant", u_if.grant, 0);
    check("rs_uart_en", u_if.uart_en, 0);
    check("rs_uart_din", u_if.uart_din, 0);
    check("rs_frame_busy", u_if.frame_busy, 0);
    check("rs_frame_done", u_if.frame_done, 0);
    check("rs_err_timeout", u_if.err_timeout, 0);
    rst = 1'b0;
    model_last = N_CH - 1;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (!u_if.tx_busy && pend == 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rs_tx_drained", seen, 1);
    rand_payload();
    do_frame(4'b0001, 1, ch);
    check("rs_restart_ch0", ch, 0);
    if (rx_q.size() > 0) check("rs_restart_hdr0", rx_q[0], 8'h55);

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
